ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures the EX results each cycle: GPR write address, write enable and ALU result, HI/LO write enables and data, and the debug instruction word.
- Handles stall bubbles and pipeline flush.
- Holds the 64-bit partial result and the cycle counter that multi-cycle EX ops (MADD/MADDU/MSUB/MSUBU) feed back into EX while EX is stalled.

---
 rtl/ex_mem_reg.sv | 74 +++++++
 tb/tb_ex_mem_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS32 core. Also holds the
// multi-cycle MADD/MSUB partial result and step count that EX reads back while stalled.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                ex_stall_i,
  input  logic                mem_stall_i,
  input  logic [31:0]         ex_inst_i,
  input  logic [ADDR_W-1:0]   ex_waddr_i,
  input  logic                ex_reg_we_i,
  input  logic [DATA_W-1:0]   ex_alu_res_i,
  input  logic                ex_hi_we_i,
  input  logic                ex_lo_we_i,
  input  logic [DATA_W-1:0]   ex_hi_i,
  input  logic [DATA_W-1:0]   ex_lo_i,
  input  logic [2*DATA_W-1:0] ex_hilo_temp_i,
  input  logic [CNT_W-1:0]    ex_cnt_i,
  output logic [31:0]         mem_inst_o,
  output logic [ADDR_W-1:0]   mem_waddr_o,
  output logic                mem_reg_we_o,
  output logic [DATA_W-1:0]   mem_alu_res_o,
  output logic                mem_hi_we_o,
  output logic                mem_lo_we_o,
  output logic [DATA_W-1:0]   mem_hi_o,
  output logic [DATA_W-1:0]   mem_lo_o,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o
);

  // Illegal ex_stall_i=0/mem_stall_i=1 falls into the advance branch on purpose.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      mem_inst_o    <= '0;
      mem_waddr_o   <= '0;
      mem_reg_we_o  <= 1'b0;
      mem_alu_res_o <= '0;
      mem_hi_we_o   <= 1'b0;
      mem_lo_we_o   <= 1'b0;
      mem_hi_o      <= '0;
      mem_lo_o      <= '0;
      hilo_temp_o   <= '0;
      cnt_o         <= '0;
    end else if (!ex_stall_i) begin
      mem_inst_o    <= ex_inst_i;
      mem_waddr_o   <= ex_waddr_i;
      mem_reg_we_o  <= ex_reg_we_i;
      mem_alu_res_o <= ex_alu_res_i;
      mem_hi_we_o   <= ex_hi_we_i;
      mem_lo_we_o   <= ex_lo_we_i;
      mem_hi_o      <= ex_hi_i;
      mem_lo_o      <= ex_lo_i;
      hilo_temp_o   <= '0;
      cnt_o         <= '0;
    end else if (!mem_stall_i) begin
      // Bubble into MEM, but keep the multi-cycle op state alive for EX.
      mem_inst_o    <= '0;
      mem_waddr_o   <= '0;
      mem_reg_we_o  <= 1'b0;
      mem_alu_res_o <= '0;
      mem_hi_we_o   <= 1'b0;
      mem_lo_we_o   <= 1'b0;
      mem_hi_o      <= '0;
      mem_lo_o      <= '0;
      hilo_temp_o   <= ex_hilo_temp_i;
      cnt_o         <= ex_cnt_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table followed by a
// randomized run, all checked through an expected-value scoreboard.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        rst, flush, ex_stall, mem_stall;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic        reg_we;
    logic [31:0] alu;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } in_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic        reg_we;
    logic [31:0] alu;
    logic        hi_we, lo_we;
    logic [31:0] hi, lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush_i, ex_stall_i, mem_stall_i;
  logic [31:0] ex_inst_i, ex_alu_res_i, ex_hi_i, ex_lo_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_reg_we_i, ex_hi_we_i, ex_lo_we_i;
  logic [63:0] ex_hilo_temp_i;
  logic [1:0]  ex_cnt_i;
  logic [31:0] mem_inst_o, mem_alu_res_o, mem_hi_o, mem_lo_o;
  logic [4:0]  mem_waddr_o;
  logic        mem_reg_we_o, mem_hi_we_o, mem_lo_we_o;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  out_t sb[$];
  out_t last;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ex_stall_i(ex_stall_i), .mem_stall_i(mem_stall_i),
    .ex_inst_i(ex_inst_i), .ex_waddr_i(ex_waddr_i), .ex_reg_we_i(ex_reg_we_i),
    .ex_alu_res_i(ex_alu_res_i), .ex_hi_we_i(ex_hi_we_i), .ex_lo_we_i(ex_lo_we_i),
    .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .ex_hilo_temp_i(ex_hilo_temp_i),
    .ex_cnt_i(ex_cnt_i),
    .mem_inst_o(mem_inst_o), .mem_waddr_o(mem_waddr_o), .mem_reg_we_o(mem_reg_we_o),
    .mem_alu_res_o(mem_alu_res_o), .mem_hi_we_o(mem_hi_we_o), .mem_lo_we_o(mem_lo_we_o),
    .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  function automatic in_t mk(logic r, logic f, logic es, logic ms, logic [31:0] inst,
                             logic [4:0] wa, logic we, logic [31:0] alu, logic hwe,
                             logic lwe, logic [31:0] hi, logic [31:0] lo,
                             logic [63:0] tmp, logic [1:0] c);
    in_t v;
    v = '{r, f, es, ms, inst, wa, we, alu, hwe, lwe, hi, lo, tmp, c};
    return v;
  endfunction

  // Expected-value builders: advance, bubble, cleared.
  function automatic out_t pt(in_t v);
    out_t o;
    o = '{v.inst, v.waddr, v.reg_we, v.alu, v.hi_we, v.lo_we, v.hi, v.lo, 64'd0, 2'd0};
    return o;
  endfunction

  function automatic out_t bub(in_t v);
    out_t o;
    o = '0;
    o.temp = v.temp;
    o.cnt  = v.cnt;
    return o;
  endfunction

  function automatic out_t model(out_t cur, in_t v);
    if (v.rst || v.flush) return '0;
    if (!v.ex_stall)      return pt(v);
    if (!v.mem_stall)     return bub(v);
    return cur;
  endfunction

  task automatic add(in_t v, out_t e);
    tbl.push_back('{v, e});
    last = e;
  endtask

  task automatic drive(in_t v);
    rst = v.rst; flush_i = v.flush; ex_stall_i = v.ex_stall; mem_stall_i = v.mem_stall;
    ex_inst_i = v.inst; ex_waddr_i = v.waddr; ex_reg_we_i = v.reg_we;
    ex_alu_res_i = v.alu; ex_hi_we_i = v.hi_we; ex_lo_we_i = v.lo_we;
    ex_hi_i = v.hi; ex_lo_i = v.lo; ex_hilo_temp_i = v.temp; ex_cnt_i = v.cnt;
  endtask

  task automatic step(string tag, in_t v, out_t e);
    out_t act, exp;
    @(negedge clk);
    drive(v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    act = '{mem_inst_o, mem_waddr_o, mem_reg_we_o, mem_alu_res_o, mem_hi_we_o,
            mem_lo_we_o, mem_hi_o, mem_lo_o, hilo_temp_o, cnt_o};
    exp = sb.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  initial begin
    in_t v;
    out_t st;
    drive('0);
    rst = 1'b1;

    // Reset with busy inputs, then release.
    v = mk(1, 0, 0, 0, 32'h1111_2222, 5'd31, 1, 32'hCAFE_F00D, 1, 1, 32'h3333_4444,
           32'h5555_6666, 64'h7777_8888_9999_AAAA, 2'd3);
    add(v, '0);
    add(v, '0);
    v.rst = 0;
    add(v, pt(v));
    // Pass-through with temp/cnt inputs ignored.
    v = mk(0, 0, 0, 0, 32'h0043_1020, 5'd3, 1, 32'hDEAD_BEEF, 1, 0, 32'h1234_5678,
           32'h0, 64'hFFFF_0000_FFFF_0000, 2'd2);
    add(v, pt(v));
    // Bubble carrying multi-cycle state, then advance.
    v = mk(0, 0, 1, 0, 32'h7000_0000, 5'd4, 1, 32'h0BAD_0BAD, 1, 1, 32'h1, 32'h2,
           64'h0000_0001_FFFF_FFFE, 2'd1);
    add(v, bub(v));
    v = mk(0, 0, 0, 0, 32'h0000_0020, 5'd9, 1, 32'h0000_0042, 0, 1, 32'h9, 32'hA,
           64'h1234, 2'd3);
    add(v, pt(v));
    // Load A5A5A5A5 then hold 3 cycles with changing inputs.
    v = mk(0, 0, 0, 0, 32'hA, 5'd17, 1, 32'hA5A5_A5A5, 1, 1, 32'hB, 32'hC, 64'h0, 2'd0);
    add(v, pt(v));
    for (int k = 0; k < 3; k++) begin
      v = mk(0, 0, 1, 1, 32'h100 + k, 5'(k), 0, 32'h5A5A_0000 + k, 0, 0, 32'hF0 + k,
             32'hE0 + k, 64'hDEAD_0000_0000 + k, 2'(k + 1));
      add(v, last);
    end
    // Flush over hold with mem_* non-zero.
    v.flush = 1;
    add(v, '0);
    // Bubble with cnt=3, hold, then flush over hold clears temp/cnt.
    v = mk(0, 0, 1, 0, 32'h1, 5'd1, 1, 32'h1, 1, 1, 32'h1, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    add(v, bub(v));
    v = mk(0, 0, 1, 1, 32'h2, 5'd2, 1, 32'h2, 1, 1, 32'h2, 32'h2, 64'h2, 2'd2);
    add(v, last);
    v.flush = 1;
    add(v, '0);
    // Illegal ex_stall=0/mem_stall=1 advances; data captured with enables low.
    v = mk(0, 0, 0, 1, 32'hFEED_FACE, 5'd30, 0, 32'h8000_0001, 0, 0, 32'hFFFF_FFFF,
           32'h8765_4321, 64'hABCD, 2'd1);
    add(v, pt(v));
    // Reset mid-op, then normal pass-through.
    v = mk(0, 0, 1, 0, 32'h3, 5'd3, 1, 32'h3, 0, 0, 32'h3, 32'h3, 64'h0000_0002_0000_0003, 2'd1);
    add(v, bub(v));
    v.rst = 1;
    add(v, '0);
    v = mk(0, 0, 0, 0, 32'h0123_4567, 5'd12, 1, 32'h7FFF_FFFF, 1, 1, 32'h0F0F_0F0F,
           32'hF0F0_F0F0, 64'h5, 2'd2);
    add(v, pt(v));

    foreach (tbl[n]) step($sformatf("vec%0d", n), tbl[n].i, tbl[n].e);

    // Randomized run against the reference model.
    st = last;
    for (int n = 0; n < 400; n++) begin
      v.rst       = ($urandom_range(0, 29) == 0);
      v.flush     = ($urandom_range(0, 14) == 0);
      v.ex_stall  = ($urandom_range(0, 2) == 0);
      v.mem_stall = ($urandom_range(0, 2) == 0);
      v.inst = $urandom; v.waddr = 5'($urandom); v.reg_we = 1'($urandom);
      v.alu = $urandom; v.hi_we = 1'($urandom); v.lo_we = 1'($urandom);
      v.hi = $urandom; v.lo = $urandom; v.temp = {$urandom, $urandom};
      v.cnt = 2'($urandom);
      st = model(st, v);
      step($sformatf("rnd%0d", n), v, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
